// File: rtl/icebus_uart_rx.sv
`timescale 1ns/1ps
// Oversampled 8N1 receiver for the ICE-board bus, feeding received bytes
// through a small first-word-fall-through FIFO with a valid/ready handshake.
module icebus_uart_rx #(
  parameter int CLKS_PER_BIT = 24,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] FULL   = NW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic r_rx_meta, r_rx_s;

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_ferr, r_ovr;
  logic          w_tick, w_push, w_pop, w_accept;

  assign w_tick = (r_cnt == '0);
  assign w_push = (r_state == ST_STOP) && w_tick && r_rx_s && rx_enable;

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_state != ST_IDLE && !rx_enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!r_rx_s && rx_enable) begin
              r_state <= ST_START;
              r_cnt   <= HALF;
            end
          end
          ST_START: begin
            if (w_tick) begin
              r_cnt <= RELOAD;
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_bit   <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              r_cnt   <= RELOAD;
              r_shift <= {r_rx_s, r_shift[7:1]};
              if (r_bit == 3'd7) r_state <= ST_STOP;
              else               r_bit   <= r_bit + 3'd1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_STOP: begin
            if (w_tick) begin
              r_cnt <= RELOAD;
              if (r_rx_s) begin
                r_state <= ST_IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= ST_BREAK;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          // A line held low after a bad stop bit must not look like a new start.
          ST_BREAK: begin
            if (r_rx_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [NW-1:0] r_count;

  assign w_pop    = m_valid && m_ready;
  assign w_accept = w_push && ((r_count < FULL) || w_pop);

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= w_push && !w_accept;
      if (w_accept) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + NW'(w_accept) - NW'(w_pop);
    end
  end

  assign m_data        = r_mem[r_rd_ptr];
  assign m_valid       = (r_count != '0);
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;
  assign busy          = (r_state != ST_IDLE);

endmodule
